// File: rtl/fft_iter_frame_io_ctrl_if.sv
// rtl/fft_iter_frame_io_ctrl_if.sv - sample stream, FFT handshake and shared RAM port bundle
interface fft_iter_frame_io_ctrl_if #(
  parameter int ADDR_WL = 5,
  parameter int DATA_WL = 32
);
  logic               IN_VALID;
  logic [DATA_WL-1:0] IN_DATA;
  logic               IN_LAST;
  logic               IN_READY;
  logic               OUT_VALID;
  logic [DATA_WL-1:0] OUT_DATA;
  logic               OUT_LAST;
  logic               OUT_READY;
  logic               FFT_START;
  logic               FFT_BUSY;
  logic [ADDR_WL-1:0] RAM_ADDR;
  logic [DATA_WL-1:0] RAM_WDATA;
  logic               RAM_WE;
  logic               RAM_RE;
  logic [DATA_WL-1:0] RAM_RDATA;
  logic               ERR_LEN;

  modport master (
    input  IN_VALID, IN_DATA, IN_LAST, OUT_READY, FFT_BUSY, RAM_RDATA,
    output IN_READY, OUT_VALID, OUT_DATA, OUT_LAST, FFT_START,
           RAM_ADDR, RAM_WDATA, RAM_WE, RAM_RE, ERR_LEN
  );

  modport slave (
    output IN_VALID, IN_DATA, IN_LAST, OUT_READY, FFT_BUSY, RAM_RDATA,
    input  IN_READY, OUT_VALID, OUT_DATA, OUT_LAST, FFT_START,
           RAM_ADDR, RAM_WDATA, RAM_WE, RAM_RE, ERR_LEN
  );
endinterface

// File: rtl/fft_iter_frame_io_ctrl.sv
// rtl/fft_iter_frame_io_ctrl.sv - frame load / FFT kick / result drain sequencer for the iterative FFT
// Define FFT_IO_BITREV_IN_EN to bit-reverse input write addresses; default writes in arrival order.
module fft_iter_frame_io_ctrl #(
  parameter int LAYERS  = 5,
  parameter int ADDR_WL = 5,
  parameter int DATA_WL = 32
) (
  input  logic CLK,
  input  logic RST,
  input  logic EN,
  fft_iter_frame_io_ctrl_if.master io
);
  localparam int N = 1 << LAYERS;
  localparam logic [ADDR_WL-1:0] CNT_LAST = ADDR_WL'(N - 1);
  localparam logic [ADDR_WL:0]   RD_END   = (ADDR_WL + 1)'(N);

  typedef enum logic [1:0] {LOAD, KICK, RUN, DRAIN} state_t;

  state_t             state;
  logic [ADDR_WL-1:0] cnt;
  logic [ADDR_WL:0]   rd_cnt;
  logic               in_ready;
  logic               fft_start;
  logic               err_len;
  logic               re_q;
  logic               re_last_q;
  logic [DATA_WL-1:0] fifo_data [2];
  logic               fifo_last [2];
  logic               wr_ptr;
  logic               rd_ptr;
  logic [1:0]         count;

  logic [ADDR_WL-1:0] wr_addr;
  logic               in_xfer;
  logic               out_valid;
  logic               pop;
  logic               fifo_pop;
  logic               push;
  logic               issue;
  logic [DATA_WL-1:0] head_data;
  logic               head_last;

  always_comb begin
    wr_addr = cnt;
`ifdef FFT_IO_BITREV_IN_EN
    for (int i = 0; i < ADDR_WL; i++) begin
      wr_addr[i] = cnt[ADDR_WL-1-i];
    end
`endif
  end

  // Read data is presented straight from RAM_RDATA when the buffer is empty, so a
  // read issued in one cycle is already offered downstream in the next.
  assign out_valid = (count != 2'd0) | re_q;
  assign head_data = (count != 2'd0) ? fifo_data[rd_ptr] : io.RAM_RDATA;
  assign head_last = (count != 2'd0) ? fifo_last[rd_ptr] : re_last_q;
  assign pop       = EN & out_valid & io.OUT_READY;
  assign fifo_pop  = pop & (count != 2'd0);
  assign push      = re_q & ~(pop & (count == 2'd0));
  assign in_xfer   = EN & io.IN_VALID & in_ready;
  assign issue     = EN & (state == DRAIN) & (rd_cnt != RD_END)
                   & ((3'(count) + 3'(re_q)) < (3'd2 + 3'(pop)));

  assign io.IN_READY  = in_ready;
  assign io.FFT_START = fft_start;
  assign io.RAM_WE    = in_xfer;
  assign io.RAM_RE    = issue;
  assign io.RAM_ADDR  = (state == DRAIN) ? rd_cnt[ADDR_WL-1:0] : wr_addr;
  assign io.RAM_WDATA = io.IN_DATA;
  assign io.OUT_VALID = out_valid;
  assign io.OUT_DATA  = head_data;
  assign io.OUT_LAST  = out_valid & head_last;
  assign io.ERR_LEN   = err_len;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= LOAD;
      cnt          <= '0;
      rd_cnt       <= '0;
      in_ready     <= 1'b1;
      fft_start    <= 1'b0;
      err_len      <= 1'b0;
      re_q         <= 1'b0;
      re_last_q    <= 1'b0;
      fifo_data[0] <= '0;
      fifo_data[1] <= '0;
      fifo_last[0] <= 1'b0;
      fifo_last[1] <= 1'b0;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      count        <= 2'd0;
    end else begin
      // A read already issued must be captured even if EN drops, since RAM_RDATA lasts one cycle.
      re_q      <= issue;
      re_last_q <= (rd_cnt == RD_END - 1'b1);
      if (push) begin
        fifo_data[wr_ptr] <= io.RAM_RDATA;
        fifo_last[wr_ptr] <= re_last_q;
        wr_ptr            <= ~wr_ptr;
      end
      if (fifo_pop) rd_ptr <= ~rd_ptr;
      case ({push, fifo_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase

      if (EN) begin
        case (state)
          LOAD: begin
            if (in_xfer) begin
              if (io.IN_LAST != (cnt == CNT_LAST)) err_len <= 1'b1;
              if (cnt == CNT_LAST) begin
                cnt       <= '0;
                state     <= KICK;
                in_ready  <= 1'b0;
                fft_start <= 1'b1;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end
          KICK: begin
            if (io.FFT_BUSY) begin
              state     <= RUN;
              fft_start <= 1'b0;
            end
          end
          RUN: begin
            if (!io.FFT_BUSY) state <= DRAIN;
          end
          DRAIN: begin
            if (issue) rd_cnt <= rd_cnt + 1'b1;
            if (pop && head_last) begin
              state    <= LOAD;
              rd_cnt   <= '0;
              cnt      <= '0;
              in_ready <= 1'b1;
            end
          end
          default: state <= LOAD;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_fft_iter_frame_io_ctrl.sv
// tb/tb_fft_iter_frame_io_ctrl.sv - self-checking bench for fft_iter_frame_io_ctrl
// Models the shared RAM and FFT core; expected outputs come from a frame-level reference model.
module tb_fft_iter_frame_io_ctrl;
  localparam int LAYERS = 5;
  localparam int N = 32;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic EN  = 1'b1;
  int checks = 0;
  int failures = 0;
  int run_len = 100;
  bit exp_err = 1'b0;
  logic [31:0] exp_ram [N];
  logic [31:0] ram [N];
  int core_t;
  bit core_act;

  fft_iter_frame_io_ctrl_if #(.ADDR_WL(5), .DATA_WL(32)) io ();

  fft_iter_frame_io_ctrl #(.LAYERS(5), .ADDR_WL(5), .DATA_WL(32)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .io(io)
  );

  always #5 CLK = ~CLK;

  initial io.RAM_RDATA = '0;
  always @(posedge CLK) begin
    if (io.RAM_WE) ram[io.RAM_ADDR] <= io.RAM_WDATA;
    if (io.RAM_RE) io.RAM_RDATA <= ram[io.RAM_ADDR];
  end

  // Core stand-in: raises BUSY two cycles after seeing START, holds it run_len cycles.
  always @(posedge CLK) begin
    if (RST) begin
      io.FFT_BUSY <= 1'b0;
      core_act    <= 1'b0;
      core_t      <= 0;
    end else if (!core_act && io.FFT_START) begin
      core_act <= 1'b1;
      core_t   <= 0;
    end else if (core_act) begin
      core_t <= core_t + 1;
      if (core_t == 1) io.FFT_BUSY <= 1'b1;
      if (core_t == 1 + run_len) begin
        io.FFT_BUSY <= 1'b0;
        core_act    <= 1'b0;
      end
    end
  end

  typedef struct {
    bit          valid;
    bit          en;
    bit          last;
    logic [31:0] data;
    bit          exp_we;
    int          exp_addr;
  } vec_t;

  vec_t tbl [39];

  function automatic int model_addr(input int i);
    int r;
    r = i;
`ifdef FFT_IO_BITREV_IN_EN
    r = 0;
    for (int b = 0; b < LAYERS; b++) if (((i >> b) & 1) == 1) r += 1 << (LAYERS - 1 - b);
`endif
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_reset_vals();
    #1;
    check("rst_in_ready", io.IN_READY, 1);
    check("rst_fft_start", io.FFT_START, 0);
    check("rst_ram_we", io.RAM_WE, 0);
    check("rst_ram_re", io.RAM_RE, 0);
    check("rst_out_valid", io.OUT_VALID, 0);
    check("rst_out_last", io.OUT_LAST, 0);
    check("rst_err_len", io.ERR_LEN, 0);
    check("rst_ram_addr", io.RAM_ADDR, 0);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    EN = 1'b1;
    io.IN_VALID = 1'b0;
    io.IN_LAST = 1'b0;
    io.IN_DATA = '0;
    io.OUT_READY = 1'b0;
    tick();
    tick();
    RST = 1'b0;
    exp_err = 1'b0;
  endtask

  task automatic load_frame(input int last_pos, input bit bubbles, input int gap_at);
    int i;
    int cyc;
    bit v;
    logic [31:0] d;
    i = 0;
    cyc = 0;
    while (i < N && cyc < 1000) begin
      if (i == gap_at) begin
        gap_at = -1;
        EN = 1'b0;
        io.IN_VALID = 1'b1;
        repeat (5) begin
          #1;
          check("gap_load_we", io.RAM_WE, 0);
          check("gap_load_ready", io.IN_READY, 1);
          tick();
        end
        EN = 1'b1;
      end
      v = bubbles ? ($urandom_range(0, 3) != 0) : 1'b1;
      d = $urandom;
      io.IN_VALID = v;
      io.IN_DATA = d;
      io.IN_LAST = (i == last_pos);
      #1;
      check("load_we", io.RAM_WE, v);
      if (v) begin
        check("load_addr", io.RAM_ADDR, model_addr(i));
        exp_ram[model_addr(i)] = d;
        if ((i == last_pos) != (i == N - 1)) exp_err = 1'b1;
        i++;
      end
      tick();
      cyc++;
    end
    io.IN_VALID = 1'b0;
    io.IN_LAST = 1'b0;
    check("load_count", i, N);
    check("load_err_len", io.ERR_LEN, exp_err);
  endtask

  task automatic drain(input int ready_pct, input bit chk_lat, input int gap_at, input int rst_at);
    int popped, issued, cyc, low_cyc, first_re, first_ov, last_pop;
    bit seen_busy, pv, gap_done;
    logic [31:0] pd;
    popped = 0; issued = 0; cyc = 0;
    low_cyc = -1; first_re = -1; first_ov = -1; last_pop = -1;
    seen_busy = 0; pv = 0; gap_done = 0; pd = '0;
    while (popped < N && cyc < 3000) begin
      if (rst_at >= 0 && popped == rst_at) begin
        RST = 1'b1;
        io.OUT_READY = 1'b0;
        tick();
        RST = 1'b0;
        exp_err = 1'b0;
        check_reset_vals();
        return;
      end
      if (gap_at >= 0 && popped == gap_at && !gap_done) begin
        gap_done = 1;
        EN = 1'b0;
        io.OUT_READY = 1'b1;
        repeat (5) begin
          #1;
          check("gap_drain_re", io.RAM_RE, 0);
          check("gap_drain_we", io.RAM_WE, 0);
          tick();
        end
        EN = 1'b1;
        pv = 0;
      end
      io.OUT_READY = ($urandom_range(0, 99) < ready_pct);
      #1;
      check("fft_start", io.FFT_START, !seen_busy);
      if (io.FFT_BUSY) seen_busy = 1;
      else if (seen_busy && low_cyc < 0) low_cyc = cyc;
      check("drain_we", io.RAM_WE, 0);
      if (io.RAM_RE) begin
        check("read_addr", io.RAM_ADDR, issued);
        if (first_re < 0) first_re = cyc;
        issued++;
      end
      if (io.OUT_VALID) begin
        if (first_ov < 0) first_ov = cyc;
        if (pv) check("stall_stable", io.OUT_DATA, pd);
        if (io.OUT_READY) begin
          check("out_data", io.OUT_DATA, exp_ram[popped]);
          check("out_last", io.OUT_LAST, popped == N - 1);
          popped++;
          last_pop = cyc;
        end
      end
      check("outstanding_le2", (issued - popped) <= 2, 1);
      pv = io.OUT_VALID && !io.OUT_READY;
      pd = io.OUT_DATA;
      tick();
      cyc++;
    end
    io.OUT_READY = 1'b0;
    check("drain_done", popped, N);
    if (chk_lat) begin
      check("lat_first_re", first_re, low_cyc + 1);
      check("lat_first_valid", first_ov, low_cyc + 2);
      check("lat_last_pop", last_pop, first_re + N);
    end
    #1;
    check("back_to_load", io.IN_READY, 1);
    check("idle_out_valid", io.OUT_VALID, 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int found;
    // Frame 1 as a vector table: bubbles at rows 3 and 20, EN held low for rows 10..14.
    k = 0;
    for (int r = 0; r < 39; r++) begin
      tbl[r].en = !(r >= 10 && r <= 14);
      tbl[r].valid = !(r == 3 || r == 20);
      tbl[r].data = k;
      tbl[r].last = (k == N - 1);
      tbl[r].exp_we = tbl[r].valid && tbl[r].en;
      tbl[r].exp_addr = model_addr(k);
      if (tbl[r].exp_we) begin
        exp_ram[model_addr(k)] = k;
        k++;
      end
    end

    do_reset();
    check_reset_vals();

    run_len = 100;
    for (int r = 0; r < 39; r++) begin
      EN = tbl[r].en;
      io.IN_VALID = tbl[r].valid;
      io.IN_DATA = tbl[r].data;
      io.IN_LAST = tbl[r].last;
      #1;
      check("tbl_we", io.RAM_WE, tbl[r].exp_we);
      if (tbl[r].exp_we) check("tbl_addr", io.RAM_ADDR, tbl[r].exp_addr);
      check("tbl_ready", io.IN_READY, 1);
      tick();
    end
    EN = 1'b1;
    io.IN_VALID = 1'b0;
    io.IN_LAST = 1'b0;
    check("tbl_start_next", io.FFT_START, 1);
    check("tbl_ready_low", io.IN_READY, 0);
    check("tbl_err_len", io.ERR_LEN, 0);
    drain(100, 1, -1, -1);

    run_len = $urandom_range(10, 60);
    load_frame(N - 1, 1, -1);
    drain(50, 0, -1, -1);

    // Early IN_LAST: sticky error, frame still 32 samples.
    load_frame(9, 1, -1);
    check("err_sticky_set", io.ERR_LEN, 1);
    drain(50, 0, -1, -1);
    load_frame(N - 1, 0, -1);
    check("err_sticky_hold", io.ERR_LEN, 1);
    drain(100, 1, -1, -1);
    do_reset();
    check_reset_vals();

    // Reset while the core runs.
    run_len = 40;
    load_frame(N - 1, 0, -1);
    found = 0;
    for (int c = 0; c < 200 && found == 0; c++) begin
      #1;
      if (!io.FFT_START && io.FFT_BUSY) found = 1;
      else tick();
    end
    check("reached_run", found, 1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check_reset_vals();

    // EN gap mid-load, then reset in the middle of the drain.
    load_frame(N - 1, 1, 17);
    drain(60, 0, -1, 12);

    load_frame(N - 1, 0, -1);
    drain(70, 0, 20, -1);

    for (int f = 0; f < 3; f++) begin
      run_len = $urandom_range(5, 80);
      load_frame(N - 1, 1, -1);
      drain((f == 0) ? 100 : $urandom_range(20, 90), f == 0, -1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
